fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the team's asynchronous FIFO among NREQ producers in the write-clock domain. Each producer offers data on a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst and drives the FIFO `winc`/`wdata` inputs. It honours `wfull` so that no write is ever issued into a full FIFO. It sits directly in front of the FIFO write side, on `wclk`.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO port arbiters: state encoding, index width
// helper and beat counter width.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int BEAT_W = 8;

  // Width of a producer index; a single bit even when clog2 would give 0.
  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after i_ptr, wrapping
// modulo NREQ. Shared by the write arbiter and the read-side scheduler.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned and no latch is inferred.
    o_idx  = '0;
    o_any  = |i_req;
    w_cand = '0;
    // Scan farthest first so the nearest candidate after the pointer wins.
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers,
// granting bounded bursts and never writing while wfull is high.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int IDW   = idw(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  gnt_valid,
  output logic [IDW-1:0]        gnt_id
);

  arb_state_t        r_state;
  logic [IDW-1:0]    r_gnt_id;
  logic [IDW-1:0]    r_last_id;
  logic [BEAT_W-1:0] r_beats;

  logic [IDW-1:0] w_pick_idx;
  logic           w_any;
  logic           w_grant;
  logic           w_sel_valid;
  logic           w_acc;
  logic           w_done;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_last_id),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  assign w_grant     = (r_state == ST_GRANT);
  assign w_sel_valid = req_valid[r_gnt_id];
  assign w_acc       = w_grant & w_sel_valid & ~wfull;
  // A full FIFO only stalls; the grant ends on burst completion or producer release.
  assign w_done      = (w_acc & (r_beats == BEAT_W'(BURST - 1))) | (~w_sel_valid & ~wfull);

  assign winc      = w_acc;
  assign gnt_valid = w_grant;
  assign gnt_id    = r_gnt_id;

  always_comb begin
    req_ready = '0;
    wdata     = '0;
    if (w_grant) wdata = req_data[r_gnt_id*DSIZE +: DSIZE];
    if (w_acc) req_ready[r_gnt_id] = 1'b1;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state   <= ST_IDLE;
      r_gnt_id  <= '0;
      r_last_id <= IDW'(NREQ - 1);
      r_beats   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt_id <= w_pick_idx;
            r_state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_last_id <= r_gnt_id;
            r_beats   <= '0;
          end else if (w_acc) begin
            r_beats <= r_beats + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
